// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry, swap FSM state type and the RGB332 to RGB444
// colour expansion shared by the pixel pipeline.
package vga_pkg;

  localparam int FB_W     = 120;
  localparam int FB_H     = 160;
  localparam int FB_DEPTH = FB_W * FB_H;

  // Buffer swap controller states.
  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // Widen RGB332 to RGB444 by replicating the top bits into the new LSBs, so
  // full-scale components stay full-scale (3'b111 -> 4'hF, 2'b11 -> 4'hF).
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] px);
    return {px[7:5], px[7], px[4:2], px[4], px[1:0], px[1:0]};
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// vga_fb_ram: double framebuffer, one write port and one registered read port.
// The buffer index selects the upper half of the storage, the pixel index the
// word inside it; the read data register lets the array map onto block RAM.
module vga_fb_ram #(
  parameter int DEPTH  = vga_pkg::FB_DEPTH,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic              wr_buf_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_buf_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);
  import vga_pkg::*;

  logic [7:0] mem_q [2][DEPTH];
  logic [7:0] rd_data_q;

  // Write port: the caller guarantees wr_addr_i < DEPTH whenever wr_en_i is high.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_buf_i][wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: registered, re-read every cycle so fresh writes show up one cycle later.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_buf_i][rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: turns sync-generator position/sync signals into 12-bit VGA
// colour plus delayed syncs, reading a double-buffered RGB332 framebuffer that
// the CPU fills through a valid/ready write port. Buffers swap on vsync fall.
module vga_pixel_pipe #(
  parameter int FB_W   = vga_pkg::FB_W,
  parameter int FB_H   = vga_pkg::FB_H,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxclk,
  input  logic [11:0]       hpos,
  input  logic [11:0]       vpos,
  input  logic              inframe,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_sel,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out
);
  import vga_pkg::*;

  localparam int                DEPTH   = FB_W * FB_H;
  localparam logic [11:0]       FB_W_P  = 12'(FB_W);
  localparam logic [11:0]       FB_H_P  = 12'(FB_H);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] W_BITS  = ADDR_W'(FB_W);

  // Pixel strobe from the sampled pixel clock
  logic pxclk_q;
  logic px_stb;

  // Stage A
  logic              valid_a_d;
  logic [ADDR_W-1:0] row_base_d;
  logic [ADDR_W-1:0] addr_a_d;
  logic              valid_a_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic              sel_a_q;
  logic              hs_a_q;
  logic              vs_a_q;

  // Stage B / C
  logic              valid_b_q;
  logic              hs_b_q;
  logic              vs_b_q;
  logic [7:0]        rd_data;
  logic [11:0]       rgb_d;

  // Swap controller
  swap_state_e       state_q;
  logic              front_sel_q;
  logic              swap_done_q;
  logic              wr_ready_q;
  logic              vs_fall;

  // Write port
  logic              wr_en;

  // Sample pxclk as data; its rising edge marks the first clk of each pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxclk_q <= 1'b0;
    end else begin
      pxclk_q <= pxclk;
    end
  end

  assign px_stb = pxclk & ~pxclk_q;

  // Pixel address = vpos*FB_W + hpos, the multiply unrolled into shift-adds of
  // the constant's set bits. Out-of-window positions read address 0 (masked later).
  always_comb begin
    row_base_d = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (W_BITS[i]) begin
        row_base_d = row_base_d + (ADDR_W'(vpos) << i);
      end
    end
    valid_a_d = inframe & (hpos < FB_W_P) & (vpos < FB_H_P);
    addr_a_d  = valid_a_d ? (row_base_d + ADDR_W'(hpos)) : '0;
  end

  // Stage A: capture address, displayed buffer and syncs once per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_q <= 1'b0;
      addr_a_q  <= '0;
      sel_a_q   <= 1'b0;
      hs_a_q    <= 1'b1;
      vs_a_q    <= 1'b1;
    end else if (px_stb) begin
      valid_a_q <= valid_a_d;
      addr_a_q  <= addr_a_d;
      sel_a_q   <= front_sel_q;
      hs_a_q    <= hsync_in;
      vs_a_q    <= vsync_in;
    end
  end

  // Stage B: move valid and syncs alongside the RAM read so they reach the pins together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_b_q <= 1'b0;
      hs_b_q    <= 1'b1;
      vs_b_q    <= 1'b1;
    end else begin
      valid_b_q <= valid_a_q;
      hs_b_q    <= hs_a_q;
      vs_b_q    <= vs_a_q;
    end
  end

  // Writes go to the back buffer; out-of-range addresses are accepted but dropped.
  assign wr_en = wr_valid & wr_ready_q & (wr_addr < DEPTH_A);

  vga_fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fb_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_buf_i  (~front_sel_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_buf_i  (sel_a_q),
    .rd_addr_i (addr_a_q),
    .rd_data_o (rd_data)
  );

  // Stage C: blank outside the framebuffer, otherwise expand RGB332 to 444.
  always_comb begin
    rgb_d = 12'h000;
    if (valid_b_q) begin
      rgb_d = rgb332_to_444(rd_data);
    end
  end

  // vs_a_q already holds vsync as of the previous pixel, so it doubles as the edge reference.
  assign vs_fall = px_stb & vs_a_q & ~vsync_in;

  // Swap controller: latch a request, flip buffers on the next vsync falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SWAP_IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      wr_ready_q  <= 1'b1;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        SWAP_IDLE: begin
          if (swap_req) begin
            state_q    <= SWAP_PENDING;
            wr_ready_q <= 1'b0;
          end
        end
        SWAP_PENDING: begin
          if (vs_fall) begin
            state_q     <= SWAP_IDLE;
            wr_ready_q  <= 1'b1;
            front_sel_q <= ~front_sel_q;
            swap_done_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= SWAP_IDLE;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready  = wr_ready_q;
  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;
  assign rgb       = rgb_d;
  assign hsync_out = hs_b_q;
  assign vsync_out = vs_b_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: randomized and directed stimulus against a behavioural
// model of the pixel pipeline (framebuffer arrays, swap bookkeeping, 2-cycle delay).
module tb_vga_pixel_pipe;

  localparam int DEPTH = 120 * 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxclk = 1'b0;
  logic [11:0] hpos = '0;
  logic [11:0] vpos = '0;
  logic        inframe = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic        front_sel;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  always #5 clk = ~clk;

  vga_pixel_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxclk     (pxclk),
    .hpos      (hpos),
    .vpos      (vpos),
    .inframe   (inframe),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .front_sel (front_sel),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit valid;
    int addr;
    bit sel;
    bit hs;
    bit vs;
  } snap_t;

  logic [7:0] fb    [2][DEPTH];
  bit         known [2][DEPTH];

  bit    m_pxprev, m_vsprev, m_front, m_pending, m_done;
  snap_t cur, snap1, snap2;
  bit    pw_v, pw_buf;
  int    pw_addr;
  logic [7:0] pw_data;

  // Stimulus for the next clock
  int         nxt_h = 0, nxt_v = 0, nxt_addr = 0;
  bit         nxt_inf = 0, nxt_hs = 1, nxt_vs = 1, nxt_px = 0, nxt_wr = 0, nxt_swap = 0;
  logic [7:0] nxt_data = '0;
  int         wq[$];

  int hl [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 118, 119};
  int vl [6]  = '{0, 1, 2, 3, 158, 159};

  // RGB332 -> RGB444 by arithmetic: 3-bit x scales as 2x + x/4, 2-bit as 5x.
  function automatic logic [11:0] exp12(input logic [7:0] p);
    int r, g, b;
    r = int'(p) / 32;
    g = (int'(p) / 4) % 8;
    b = int'(p) % 4;
    return 12'((2 * r + r / 4) * 256 + (2 * g + g / 4) * 16 + 5 * b);
  endfunction

  function automatic int rand_set_addr();
    return vl[$urandom_range(0, 5)] * 120 + hl[$urandom_range(0, 9)];
  endfunction

  task automatic model_reset();
    m_pxprev = 0; m_vsprev = 1; m_front = 0; m_pending = 0; m_done = 0;
    cur = '{valid: 0, addr: 0, sel: 0, hs: 1, vs: 1};
    snap1 = cur;
    snap2 = cur;
    pw_v = 0;
  endtask

  task automatic check_outputs();
    if (snap2.valid) begin
      if (known[snap2.sel][snap2.addr])
        check_eq("rgb", 32'(rgb), 32'(exp12(fb[snap2.sel][snap2.addr])));
    end else begin
      check_eq("rgb_blank", 32'(rgb), 32'(0));
    end
    check_eq("hsync_out", 32'(hsync_out), 32'(snap2.hs));
    check_eq("vsync_out", 32'(vsync_out), 32'(snap2.vs));
    check_eq("front_sel", 32'(front_sel), 32'(m_front));
    check_eq("swap_done", 32'(swap_done), 32'(m_done));
    check_eq("wr_ready", 32'(wr_ready), 32'(!m_pending));
    if (swap_done === 1'b1) begin
      done_cnt++;
      $display("swap_done: front_sel=%0d t=%0t", front_sel, $time);
    end
  endtask

  task automatic commit();
    if (pw_v) begin
      fb[pw_buf][pw_addr] = pw_data;
      known[pw_buf][pw_addr] = 1;
      pw_v = 0;
    end
  endtask

  task automatic apply();
    bit stb, fall;
    pxclk = nxt_px; hpos = 12'(nxt_h); vpos = 12'(nxt_v); inframe = nxt_inf;
    hsync_in = nxt_hs; vsync_in = nxt_vs; wr_valid = nxt_wr; wr_addr = 15'(nxt_addr);
    wr_data = nxt_data; swap_req = nxt_swap;

    snap2 = snap1;
    stb = nxt_px && !m_pxprev;
    m_pxprev = nxt_px;
    fall = stb && m_vsprev && !nxt_vs;
    if (stb) m_vsprev = nxt_vs;
    m_done = 0;
    if (nxt_wr && !m_pending) begin
      $display("write: addr=%0d data=%02h buf=%0d%s", nxt_addr, nxt_data, !m_front,
               (nxt_addr >= DEPTH) ? " (dropped)" : "");
      if (nxt_addr < DEPTH) begin
        pw_v = 1; pw_buf = !m_front; pw_addr = nxt_addr; pw_data = nxt_data;
      end
    end
    if (stb) begin
      cur.valid = nxt_inf && nxt_h < 120 && nxt_v < 160;
      cur.addr  = cur.valid ? nxt_v * 120 + nxt_h : 0;
      cur.sel   = m_front;
      cur.hs    = nxt_hs;
      cur.vs    = nxt_vs;
    end
    if (m_pending && fall) begin
      m_front = !m_front; m_pending = 0; m_done = 1;
    end else if (!m_pending && nxt_swap) begin
      m_pending = 1;
    end
    snap1 = cur;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    commit();
    apply();
  endtask

  task automatic reset_values(input string tag);
    check_eq({tag, "_rgb"}, 32'(rgb), 32'(0));
    check_eq({tag, "_hs"}, 32'(hsync_out), 32'(1));
    check_eq({tag, "_vs"}, 32'(vsync_out), 32'(1));
    check_eq({tag, "_sel"}, 32'(front_sel), 32'(0));
    check_eq({tag, "_done"}, 32'(swap_done), 32'(0));
    check_eq({tag, "_ready"}, 32'(wr_ready), 32'(1));
  endtask

  task automatic do_reset(input bit async_check);
    @(negedge clk);
    commit();
    if (async_check) begin
      #2 rst_n = 1'b0;
      #1 reset_values("rst_async");
    end else begin
      rst_n = 1'b0;
    end
    nxt_px = 0; nxt_wr = 0; nxt_swap = 0; nxt_inf = 0; nxt_hs = 1; nxt_vs = 1;
    pxclk = 0; wr_valid = 0; swap_req = 0; inframe = 0; hsync_in = 1; vsync_in = 1;
    repeat (3) @(negedge clk);
    reset_values("rst_hold");
    $display("reset released t=%0t", $time);
    rst_n = 1'b1;
    model_reset();
    apply();
  endtask

  task automatic pixel(input int h, input int v, input bit inf, input bit hs, input bit vs,
                       input bit rnd);
    int w;
    for (int c = 0; c < 4; c++) begin
      nxt_px = (c < 2); nxt_h = h; nxt_v = v; nxt_inf = inf; nxt_hs = hs; nxt_vs = vs;
      if (rnd) begin
        nxt_wr   = ($urandom_range(0, 2) == 0);
        nxt_addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 32767)) : rand_set_addr();
        nxt_data = 8'($urandom);
        nxt_swap = ($urandom_range(0, 39) == 0);
      end else if (wq.size() > 0) begin
        w = wq.pop_front();
        nxt_wr = 1; nxt_addr = w / 256; nxt_data = 8'(w % 256);
      end
      step();
      nxt_wr = 0; nxt_swap = 0;
    end
  endtask

  task automatic fill_set(input bit marker);
    if (marker) wq.push_back(8'hE0);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 10; j++)
        if (!(marker && vl[i] == 0 && hl[j] == 0))
          wq.push_back((vl[i] * 120 + hl[j]) * 256 + int'($urandom_range(0, 255)));
    while (wq.size() > 0) pixel(0, 0, 0, 1, 1, 0);
  endtask

  function automatic int rand_h();
    int i = $urandom_range(0, 11);
    return (i < 10) ? hl[i] : ((i == 10) ? 120 : 200);
  endfunction

  function automatic int rand_v();
    int i = $urandom_range(0, 7);
    return (i < 6) ? vl[i] : ((i == 6) ? 160 : 3000);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    model_reset();
    do_reset(0);

    // Blank frame: no writes, random syncs, colour must stay black.
    for (int p = 0; p < 30; p++)
      pixel(rand_h(), rand_v(), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    pixel(0, 0, 0, 1, 1, 0);

    // Fill back buffer 1 (E0 at address 0), plus an out-of-range write.
    fill_set(1);
    wq.push_back(DEPTH * 256 + 8'hFF);
    pixel(0, 0, 0, 1, 1, 0);

    // Swap on the next vsync fall.
    d0 = done_cnt;
    nxt_swap = 1;
    pixel(0, 0, 0, 1, 1, 0);
    pixel(0, 0, 0, 1, 0, 0);
    pixel(0, 0, 0, 1, 1, 0);
    check_eq("swap1_sel", 32'(front_sel), 32'(1));
    check_eq("swap1_once", 32'(done_cnt - d0), 32'(1));

    // Fill the new back buffer 0.
    fill_set(0);

    // Displayed pixels from buffer 1.
    pixel(0, 0, 1, 1, 1, 0);
    check_eq("px00_f00", 32'(rgb), 32'(12'hF00));
    pixel(120, 0, 1, 1, 1, 0);
    check_eq("h120_blank", 32'(rgb), 32'(0));
    pixel(119, 159, 1, 1, 1, 0);

    // swap_req coincident with a vsync fall: recorded, swap at the next fall.
    nxt_swap = 1;
    pixel(1, 1, 1, 1, 0, 0);
    check_eq("same_edge_hold", 32'(front_sel), 32'(1));
    for (int p = 0; p < 20; p++) begin
      wq.push_back(rand_set_addr() * 256 + int'($urandom_range(0, 255)));
      pixel(rand_h(), rand_v(), 1, 1'($urandom_range(0, 1)), 1, 0);
    end
    wq.delete();
    pixel(2, 2, 1, 1, 0, 0);
    pixel(2, 2, 1, 1, 1, 0);
    check_eq("same_edge_next", 32'(front_sel), 32'(0));

    // Second request while pending: exactly one swap.
    d0 = done_cnt;
    nxt_swap = 1;
    pixel(3, 3, 1, 1, 1, 0);
    nxt_swap = 1;
    pixel(4, 3, 1, 1, 1, 0);
    pixel(5, 3, 1, 1, 0, 0);
    for (int p = 0; p < 3; p++) pixel(rand_h(), rand_v(), 1, 1, 1, 0);
    check_eq("dbl_req_once", 32'(done_cnt - d0), 32'(1));
    check_eq("dbl_req_sel", 32'(front_sel), 32'(1));

    // Random traffic with periodic vsync.
    for (int p = 0; p < 600; p++)
      pixel(rand_h(), rand_v(), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
            (p % 50 < 3) ? 1'b0 : 1'b1, 1);
    pixel(0, 0, 1, 1, 1, 0);

    // Reset mid-line with a swap pending: no swap afterwards.
    nxt_swap = 1;
    pixel(2, 2, 1, 1, 1, 0);
    pixel(0, 0, 1, 0, 1, 0);
    do_reset(1);
    d0 = done_cnt;
    pixel(0, 0, 1, 1, 1, 0);
    pixel(1, 0, 1, 1, 0, 0);
    for (int p = 0; p < 3; p++) pixel(rand_h(), rand_v(), 1, 1, 1, 0);
    check_eq("rst_no_swap", 32'(done_cnt - d0), 32'(0));
    check_eq("rst_front", 32'(front_sel), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
